// File: rtl/comp_pkg.sv
// comp_pkg: shared defaults and width/index helpers for the comp_mac block.
`default_nettype none

package comp_pkg;

    localparam int DEF_P_SIZE  = 8;
    localparam int DEF_N_CH    = 4;
    localparam int DEF_P_LAT   = 2;
    localparam int DEF_P_GUARD = 4;

    function automatic int acc_width(input int p_size, input int p_guard);
        return 2 * p_size + p_guard;
    endfunction

    // Low bit of channel k inside a packed bus of w-bit channels.
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/comp_mac_lane.sv
// comp_mac_lane: one channel of comp_mac -- pipelined unsigned multiply plus accumulator.
// Accumulator saturates when COMP_MAC_SAT_EN is defined, otherwise wraps.
`default_nettype none

module comp_mac_lane #(
    parameter int P_SIZE = 8,
    parameter int P_LAT  = 2,
    parameter int ACC_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [P_SIZE-1:0]     a,
    input  logic [P_SIZE-1:0]     b,
    input  logic                  vld,
    input  logic                  clr,
    output logic [2*P_SIZE-1:0]   prod,
    output logic [ACC_W-1:0]      acc,
    output logic                  ovf
);

    logic [2*P_SIZE-1:0] mul;
    logic [2*P_SIZE-1:0] mul_out;
    logic [ACC_W:0]      prod_ext;
    logic [ACC_W:0]      sum;
    logic [ACC_W-1:0]    acc_next;
    logic                carry;

    assign mul = {{P_SIZE{1'b0}}, a} * {{P_SIZE{1'b0}}, b};

    // The final pipeline stage is the accumulator register itself, so only
    // P_LAT-1 product registers sit in front of it.
    generate
        if (P_LAT == 1) begin : g_no_pipe
            assign mul_out = mul;
        end else begin : g_pipe
            logic [2*P_SIZE-1:0] mul_q [P_LAT-1];
            always_ff @(posedge clk) begin
                mul_q[0] <= mul;
                for (int i = 1; i < P_LAT - 1; i++) begin
                    mul_q[i] <= mul_q[i-1];
                end
            end
            assign mul_out = mul_q[P_LAT-2];
        end
    endgenerate

    assign prod_ext = {{(ACC_W + 1 - 2*P_SIZE){1'b0}}, mul_out};
    assign sum      = {1'b0, acc} + prod_ext;
    assign carry    = sum[ACC_W];

    always_comb begin
        acc_next = sum[ACC_W-1:0];
`ifdef COMP_MAC_SAT_EN
        if (carry) begin
            acc_next = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= '0;
            acc  <= '0;
            ovf  <= 1'b0;
        end else if (vld) begin
            prod <= mul_out;
            if (clr) begin
                acc <= prod_ext[ACC_W-1:0];
                ovf <= 1'b0;
            end else begin
                acc <= acc_next;
                if (carry) begin
                    ovf <= 1'b1;
                end
            end
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/comp_mac.sv
// comp_mac: N_CH-channel unsigned multiply-accumulate with shared valid/clear tag pipeline.
// Optional macro COMP_MAC_SAT_EN selects saturating accumulators (default: wrap).
`default_nettype none

module comp_mac
    import comp_pkg::*;
#(
    parameter int P_SIZE  = DEF_P_SIZE,
    parameter int N_CH    = DEF_N_CH,
    parameter int P_LAT   = DEF_P_LAT,
    parameter int P_GUARD = DEF_P_GUARD
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_CH*P_SIZE-1:0]                    i_param,
    input  logic [N_CH*P_SIZE-1:0]                    i_param_2,
    input  logic                                      ena,
    input  logic                                      i_clr,
    output logic [N_CH*2*P_SIZE-1:0]                  o_param,
    output logic [N_CH*acc_width(P_SIZE, P_GUARD)-1:0] o_param_2,
    output logic                                      dv,
    output logic [N_CH-1:0]                           o_ovf
);

    localparam int ACC_W = acc_width(P_SIZE, P_GUARD);

    logic vld_out;
    logic clr_out;

    generate
        if (P_LAT == 1) begin : g_no_pipe
            assign vld_out = ena;
            assign clr_out = i_clr;
        end else begin : g_pipe
            logic [P_LAT-2:0] vld_q;
            logic [P_LAT-2:0] clr_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    clr_q <= '0;
                end else begin
                    vld_q[0] <= ena;
                    clr_q[0] <= i_clr;
                    for (int i = 1; i < P_LAT - 1; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        clr_q[i] <= clr_q[i-1];
                    end
                end
            end
            assign vld_out = vld_q[P_LAT-2];
            assign clr_out = clr_q[P_LAT-2];
        end
    endgenerate

    // dv is registered alongside the accumulators so it marks the cycle they change.
    always_ff @(posedge clk) begin
        if (rst) begin
            dv <= 1'b0;
        end else begin
            dv <= vld_out;
        end
    end

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_lane
            comp_mac_lane #(
                .P_SIZE (P_SIZE),
                .P_LAT  (P_LAT),
                .ACC_W  (ACC_W)
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .a    (i_param[lane_lo(k, P_SIZE) +: P_SIZE]),
                .b    (i_param_2[lane_lo(k, P_SIZE) +: P_SIZE]),
                .vld  (vld_out),
                .clr  (clr_out),
                .prod (o_param[lane_lo(k, 2*P_SIZE) +: 2*P_SIZE]),
                .acc  (o_param_2[lane_lo(k, ACC_W) +: ACC_W]),
                .ovf  (o_ovf[k])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_comp_mac.sv
// tb_comp_mac: directed and randomized checks of comp_mac against a cycle-indexed behavioural model.
`default_nettype none

module tb_comp_mac;

    localparam int P_SIZE  = 4;
    localparam int N_CH    = 2;
    localparam int P_LAT   = 2;
    localparam int P_GUARD = 1;
    localparam int ACC_W   = 2*P_SIZE + P_GUARD;
    localparam int ACC_MAX = (1 << ACC_W) - 1;
    localparam int HIST    = 8192;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_CH*P_SIZE-1:0]    i_param;
    logic [N_CH*P_SIZE-1:0]    i_param_2;
    logic                      ena;
    logic                      i_clr;
    logic [N_CH*2*P_SIZE-1:0]  o_param;
    logic [N_CH*ACC_W-1:0]     o_param_2;
    logic                      dv;
    logic [N_CH-1:0]           o_ovf;

    comp_mac #(
        .P_SIZE  (P_SIZE),
        .N_CH    (N_CH),
        .P_LAT   (P_LAT),
        .P_GUARD (P_GUARD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_param   (i_param),
        .i_param_2 (i_param_2),
        .ena       (ena),
        .i_clr     (i_clr),
        .o_param   (o_param),
        .o_param_2 (o_param_2),
        .dv        (dv),
        .o_ovf     (o_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: every beat is logged by the edge that captured it and applied
    // P_LAT-1 edges later; a reset edge discards everything not yet applied.
    bit                    h_ena [HIST];
    bit                    h_clr [HIST];
    logic [N_CH*P_SIZE-1:0] h_a  [HIST];
    logic [N_CH*P_SIZE-1:0] h_b  [HIST];
    int cyc = 0;
    int m_prod [N_CH];
    int m_acc  [N_CH];
    bit m_ovf  [N_CH];
    bit m_dv = 1'b0;

    always @(posedge clk) begin
        int e;
        int p;
        int s;
        h_ena[cyc] = ena;
        h_clr[cyc] = i_clr;
        h_a[cyc]   = i_param;
        h_b[cyc]   = i_param_2;
        if (rst) begin
            for (int j = 0; j < P_LAT; j++) begin
                if (cyc - j >= 0) begin
                    h_ena[cyc-j] = 1'b0;
                    h_clr[cyc-j] = 1'b0;
                end
            end
            m_dv = 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                m_prod[k] = 0;
                m_acc[k]  = 0;
                m_ovf[k]  = 1'b0;
            end
        end else begin
            e = cyc - (P_LAT - 1);
            m_dv = 1'b0;
            if (e >= 0) begin
                if (h_ena[e]) begin
                    m_dv = 1'b1;
                    for (int k = 0; k < N_CH; k++) begin
                        p = int'(h_a[e][k*P_SIZE +: P_SIZE]) * int'(h_b[e][k*P_SIZE +: P_SIZE]);
                        m_prod[k] = p;
                        if (h_clr[e]) begin
                            m_acc[k] = p;
                            m_ovf[k] = 1'b0;
                        end else begin
                            s = m_acc[k] + p;
                            if (s > ACC_MAX) begin
                                m_ovf[k] = 1'b1;
`ifdef COMP_MAC_SAT_EN
                                s = ACC_MAX;
`else
                                s = s - (ACC_MAX + 1);
`endif
                            end
                            m_acc[k] = s;
                        end
                    end
                end else if (h_clr[e]) begin
                    for (int k = 0; k < N_CH; k++) begin
                        m_acc[k] = 0;
                        m_ovf[k] = 1'b0;
                    end
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        logic [N_CH*2*P_SIZE-1:0] ep;
        logic [N_CH*ACC_W-1:0]    ea;
        logic [N_CH-1:0]          eo;
        if (check_en) begin
            for (int k = 0; k < N_CH; k++) begin
                ep[k*2*P_SIZE +: 2*P_SIZE] = m_prod[k][2*P_SIZE-1:0];
                ea[k*ACC_W +: ACC_W]       = m_acc[k][ACC_W-1:0];
                eo[k]                      = m_ovf[k];
            end
            chk("model_dv",   64'(dv),        64'(m_dv));
            chk("model_prod", 64'(o_param),   64'(ep));
            chk("model_acc",  64'(o_param_2), 64'(ea));
            chk("model_ovf",  64'(o_ovf),     64'(eo));
        end
    end

    task automatic step(input logic r, input logic e, input logic c,
                        input logic [7:0] a, input logic [7:0] b);
        rst       = r;
        ena       = e;
        i_clr     = c;
        i_param   = a;
        i_param_2 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; i_clr = 1'b0; i_param = '0; i_param_2 = '0;
        step(1, 0, 0, 8'h00, 8'h00);
        check_en = 1'b1;
        step(1, 0, 0, 8'h00, 8'h00);
        chk("reset_dv",   64'(dv),        64'd0);
        chk("reset_prod", 64'(o_param),   64'd0);
        chk("reset_acc",  64'(o_param_2), 64'd0);
        chk("reset_ovf",  64'(o_ovf),     64'd0);

        // Latency: A={15,3} B={15,5} (ch1,ch0), dv only on the second edge.
        step(0, 1, 1, {4'd15, 4'd3}, {4'd15, 4'd5});
        chk("lat_dv_early", 64'(dv), 64'd0);
        step(0, 0, 0, 8'h00, 8'h00);
        chk("lat_dv",   64'(dv),        64'd1);
        chk("lat_prod", 64'(o_param),   64'({8'd225, 8'd15}));
        chk("lat_acc",  64'(o_param_2), 64'({9'd225, 9'd15}));
        step(0, 0, 0, 8'h00, 8'h00);
        chk("lat_dv_after", 64'(dv), 64'd0);
        chk("lat_hold",     64'(o_param_2), 64'({9'd225, 9'd15}));

        // Back-to-back accumulation of 2*2.
        step(0, 1, 1, 8'h22, 8'h22);
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) step(0, 1, 0, 8'h22, 8'h22);
            else       step(0, 0, 0, 8'h00, 8'h00);
            chk("b2b_dv",  64'(dv), 64'd1);
            chk("b2b_acc", 64'(o_param_2), 64'({9'(4*i), 9'(4*i)}));
        end
        step(0, 0, 0, 8'h00, 8'h00);
        chk("b2b_dv_end", 64'(dv), 64'd0);

        // Overflow on ch1, ch0 accumulates 1 per beat.
        step(0, 1, 1, {4'd15, 4'd1}, {4'd15, 4'd1});
        step(0, 1, 0, {4'd15, 4'd1}, {4'd15, 4'd1});
        step(0, 1, 0, {4'd15, 4'd1}, {4'd15, 4'd1});
        chk("ovf_450", 64'(o_param_2), 64'({9'd450, 9'd2}));
        chk("ovf_none", 64'(o_ovf), 64'd0);
        step(0, 0, 0, 8'h00, 8'h00);
`ifdef COMP_MAC_SAT_EN
        chk("ovf_acc", 64'(o_param_2), 64'({9'd511, 9'd3}));
`else
        chk("ovf_acc", 64'(o_param_2), 64'({9'd163, 9'd3}));
`endif
        chk("ovf_flag", 64'(o_ovf), 64'b10);

        // Clear slot without a valid beat.
        step(0, 0, 1, 8'h00, 8'h00);
        step(0, 0, 0, 8'h00, 8'h00);
        chk("clr_acc",  64'(o_param_2), 64'd0);
        chk("clr_ovf",  64'(o_ovf),     64'd0);
        chk("clr_dv",   64'(dv),        64'd0);
        chk("clr_prod", 64'(o_param),   64'({8'd225, 8'd1}));

        // Reset while two beats are in flight.
        step(0, 1, 1, 8'hff, 8'hff);
        step(1, 1, 0, 8'hff, 8'hff);
        chk("rst_mid_dv0", 64'(dv), 64'd0);
        step(0, 0, 0, 8'h00, 8'h00);
        chk("rst_mid_dv1", 64'(dv), 64'd0);
        step(0, 0, 0, 8'h00, 8'h00);
        chk("rst_mid_dv2",  64'(dv),        64'd0);
        chk("rst_mid_acc",  64'(o_param_2), 64'd0);
        chk("rst_mid_prod", 64'(o_param),   64'd0);
        chk("rst_mid_ovf",  64'(o_ovf),     64'd0);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0),
                 8'($urandom), 8'($urandom));
        end
        step(0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/comp_mac.md
COMP_MAC -- requirements
Module: comp_mac

Interface
REQ-001 SHALL have parameter P_SIZE, default 8: per-channel operand width, 1..32.
REQ-002 SHALL have parameter N_CH, default 4: number of independent channels, 1..16.
REQ-003 SHALL have parameter P_LAT, default 2: multiply pipeline latency in cycles, 1..4.
REQ-004 SHALL have parameter P_GUARD, default 4: accumulator guard bits; ACC_W = 2*P_SIZE + P_GUARD.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_param  in  N_CH*P_SIZE  operand A, channel k at bits [k*P_SIZE +: P_SIZE].
REQ-008 SHALL have port i_param_2  in  N_CH*P_SIZE  operand B, same packing.
REQ-009 SHALL have port ena  in  1  input beat valid.
REQ-010 SHALL have port i_clr  in  1  accumulator clear tag for this cycle.
REQ-011 SHALL have port o_param  out  N_CH*2*P_SIZE  per-channel product of the emerging beat.
REQ-012 SHALL have port o_param_2  out  N_CH*ACC_W  per-channel running accumulation.
REQ-013 SHALL have port dv  out  1  o_param/o_param_2 updated by a valid beat this cycle.
REQ-014 SHALL have port o_ovf  out  N_CH  per-channel sticky overflow flag.

Function
REQ-015 SHALL treat all operands, products and sums as unsigned.
REQ-016 SHALL compute, per channel, product = A*B at full 2*P_SIZE width, no truncation.
REQ-017 SHALL carry {ena, i_clr, operands} through a P_LAT-stage pipeline that advances every cycle (no backpressure, no stall).
REQ-018 SHALL assert dv for exactly one cycle, P_LAT cycles after each cycle with ena=1; back-to-back beats yield back-to-back dv.
REQ-019 SHALL, on a beat emerging with ena=1 and i_clr=0, update acc <= acc + product.
REQ-020 SHALL, on a beat emerging with ena=1 and i_clr=1, load acc <= product and clear o_ovf for that channel.
REQ-021 SHALL, on a slot emerging with ena=0 and i_clr=1, set acc <= 0 and clear o_ovf, with dv=0.
REQ-022 SHALL hold o_param, o_param_2 and o_ovf unchanged in slots with ena=0 and i_clr=0.
REQ-023 SHALL, in wrap mode, keep acc modulo 2^ACC_W on overflow and set o_ovf[k] sticky until cleared.
REQ-024 SHALL drive o_param_2 directly from the accumulator register, reflecting the update in the same cycle dv is high.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, zero all pipeline valid/clear tags, accumulators, o_param and o_ovf, and drive dv=0.
REQ-026 SHALL discard in-flight beats on reset mid-operation; no dv for beats entered before or during reset.
REQ-027 SHALL accept a beat on the first edge after rst deasserts, producing dv P_LAT cycles later.

Configuration
REQ-028 SHALL, with macro COMP_MAC_SAT_EN defined, clamp acc to 2^ACC_W-1 on overflow and set o_ovf[k] sticky.
REQ-029 SHALL, without COMP_MAC_SAT_EN, use wrap behaviour per REQ-023; the interface is identical in both builds.

Structure
REQ-030 SHALL define in shared package comp_pkg: parameter defaults, the ACC_W derivation function, and the channel slice-index helper.
REQ-031 SHALL instantiate N_CH copies of sub-module comp_mac_lane (one channel: multiply pipe plus accumulator), with valid/clear tag pipeline shared in comp_mac.

Verification (P_SIZE=4, N_CH=2, P_LAT=2, P_GUARD=1, ACC_W=9)
REQ-032 SHALL cover latency: ena=1, i_clr=1, A={3,15}, B={5,15} at cycle 0 -> dv=1 only at cycle 2, o_param={15,225}, o_param_2={15,225}.
REQ-033 SHALL cover back-to-back accumulation: 4 consecutive beats A=B={2,2}, first with i_clr=1 -> dv high 4 cycles, o_param_2 steps 4,8,12,16 per channel.
REQ-034 SHALL cover overflow: ch1 acc=225 then beat 15*15 -> wrap build o_param_2[ch1]=450-512+... =450 mod 512=450, no ovf; third beat -> 675 mod 512=163, o_ovf[1]=1; SAT build -> 511, o_ovf[1]=1; ch0 unaffected.
REQ-035 SHALL cover clear slot: ena=0, i_clr=1 -> 2 cycles later accumulators=0, o_ovf=0, dv=0.
REQ-036 SHALL cover reset mid-flight: beats at cycles 0,1, rst=1 at cycle 1 -> no dv at cycles 2,3, all outputs zero after reset.
